uart_receiver: RTL and testbench

UART 8N1 receive path: the counterpart of the team's transmitter on the same serial line. It oversamples RxD using a tick strobe that runs at OVERSAMPLE × baud, detects the start bit and samples each bit at mid-bit. Data is assembled LSB-first in a receive shift register (RSDR), then moved into a holding register (RDR). Status flags are exposed to the host-side logic, all in the clk domain.

---
 rtl/uart_receiver.sv | 171 +++++++++++++++++
 tb/tb_uart_receiver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: synchronizes RxD, oversamples with rx_tick, samples mid-bit,
// assembles LSB-first into RSDR and delivers to RDR with RF/OE/FE status.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_tick,
  input  logic       RxD,
  input  logic       read,
  output logic [7:0] dout,
  output logic       RF,
  output logic       OE,
  output logic       FE,
  output logic       busy
);

  localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BW = 4;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [TW-1:0]          r_tcnt;
  logic [TW-1:0]          w_tcnt_nxt;
  logic [BW-1:0]          r_bcnt;
  logic [BW-1:0]          w_bcnt_nxt;
  logic [7:0]             r_rsdr;
  logic [7:0]             w_rsdr_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;
  logic                   w_deliver;
  logic [7:0]             r_dout;
  logic                   r_rf;
  logic                   r_oe;
  logic                   r_fe;
  logic                   r_busy;

  // RxD synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], RxD};
    end
  end

  assign w_rxs = r_sync[SYNC_STAGES-1];

  // FSM and datapath state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_rsdr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_rsdr  <= w_rsdr_nxt;
    end
  end

  // Next-state logic; everything advances only on rx_tick
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_bcnt_nxt  = r_bcnt;
    w_rsdr_nxt  = r_rsdr;
    w_deliver   = 1'b0;
    if (rx_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            w_state_nxt = S_START;
            w_tcnt_nxt  = '0;
          end
        end
        S_START: begin
          if (r_tcnt == TICK_MID) begin
            w_tcnt_nxt = '0;
            if (!w_rxs) begin
              w_state_nxt = S_DATA;
              w_bcnt_nxt  = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
          end
        end
        S_DATA: begin
          if (r_tcnt == TICK_LAST) begin
            w_tcnt_nxt = '0;
            w_rsdr_nxt = {w_rxs, r_rsdr[7:1]};
            w_bcnt_nxt = r_bcnt + BW'(1);
            if (r_bcnt == BIT_LAST) begin
              w_state_nxt = S_STOP;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
          end
        end
        S_STOP: begin
          if (r_tcnt == TICK_LAST) begin
            w_tcnt_nxt  = '0;
            w_deliver   = 1'b1;
            w_state_nxt = w_rxs ? S_IDLE : S_BREAK;
          end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
          end
        end
        S_BREAK: begin
          // hold off start detection until the line has returned high
          if (w_rxs) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Host-side holding register and status; a delivery takes priority over read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dout <= '0;
      r_rf   <= 1'b0;
      r_oe   <= 1'b0;
      r_fe   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_deliver) begin
        r_fe <= ~w_rxs;
        if (!r_rf || read) begin
          r_dout <= r_rsdr;
          r_rf   <= 1'b1;
          r_oe   <= 1'b0;
        end else begin
          r_oe <= 1'b1;
        end
      end else if (read && r_rf) begin
        r_rf <= 1'b0;
        r_oe <= 1'b0;
        r_fe <= 1'b0;
      end
    end
  end

  assign dout = r_dout;
  assign RF   = r_rf;
  assign OE   = r_oe;
  assign FE   = r_fe;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: OVERSAMPLE=16, rx_tick every 4 clk (64 clk per bit).
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_tick;
  logic       RxD;
  logic       read;
  logic [7:0] dout;
  logic       RF;
  logic       OE;
  logic       FE;
  logic       busy;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        rf_pre;
  logic        rf_post;

  uart_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .rx_tick (rx_tick),
    .RxD     (RxD),
    .read    (read),
    .dout    (dout),
    .RF      (RF),
    .OE      (OE),
    .FE      (FE),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign rx_tick = (cyc[1:0] == 2'b11);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame, started on a tick-phase-aligned negedge so the
  // stop-bit sample lands on the 612th posedge after the start edge.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic rd_stop);
    while (cyc[1:0] != 2'b00) @(negedge clk);
    RxD = 1'b0;
    repeat (64) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      RxD = d[b];
      if (b == 4) chk("busy_mid_frame", {7'd0, busy}, 8'h01);
      repeat (64) @(negedge clk);
    end
    RxD = stop_bit;
    for (int i = 0; i < 64; i++) begin
      if (i == 35) begin
        rf_pre = RF;
        if (rd_stop) read = 1'b1;
      end
      if (i == 36) begin
        rf_post = RF;
        read    = 1'b0;
      end
      @(negedge clk);
    end
    RxD = 1'b1;
  endtask

  task automatic pulse_read();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    RxD    = 1'b1;
    read   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 8'h00);
    chk("rst_rf", {7'd0, RF}, 8'h00);
    chk("rst_oe", {7'd0, OE}, 8'h00);
    chk("rst_fe", {7'd0, FE}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    resetn = 1'b1;
    repeat (20) @(negedge clk);

    // single byte, with RF latency around the stop-bit sample edge
    send_byte(8'hA5, 1'b1, 1'b0);
    chk("a5_rf_before_edge", {7'd0, rf_pre}, 8'h00);
    chk("a5_rf_after_edge", {7'd0, rf_post}, 8'h01);
    repeat (4) @(negedge clk);
    chk("a5_dout", dout, 8'hA5);
    chk("a5_rf", {7'd0, RF}, 8'h01);
    chk("a5_oe", {7'd0, OE}, 8'h00);
    chk("a5_fe", {7'd0, FE}, 8'h00);
    chk("a5_busy", {7'd0, busy}, 8'h00);
    pulse_read();
    chk("a5_read_rf", {7'd0, RF}, 8'h00);

    // back-to-back without read: overrun, first byte kept
    send_byte(8'h3C, 1'b1, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("ovr_dout", dout, 8'h3C);
    chk("ovr_rf", {7'd0, RF}, 8'h01);
    chk("ovr_oe", {7'd0, OE}, 8'h01);
    pulse_read();
    chk("ovr_read_rf", {7'd0, RF}, 8'h00);
    chk("ovr_read_oe", {7'd0, OE}, 8'h00);

    // read coinciding with delivery: delivery wins
    send_byte(8'h3C, 1'b1, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("coin_dout", dout, 8'hC3);
    chk("coin_rf", {7'd0, RF}, 8'h01);
    chk("coin_oe", {7'd0, OE}, 8'h00);
    pulse_read();

    // framing error then line held low: no phantom frame
    send_byte(8'h55, 1'b0, 1'b0);
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    chk("fe_dout", dout, 8'h55);
    chk("fe_fe", {7'd0, FE}, 8'h01);
    repeat (188) @(negedge clk);
    chk("brk_busy_low_line", {7'd0, busy}, 8'h01);
    RxD = 1'b1;
    repeat (64) @(negedge clk);
    chk("brk_busy_idle", {7'd0, busy}, 8'h00);
    chk("brk_oe", {7'd0, OE}, 8'h00);
    chk("brk_dout", dout, 8'h55);
    pulse_read();
    chk("brk_read_fe", {7'd0, FE}, 8'h00);
    send_byte(8'h0F, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("f0_dout", dout, 8'h0F);
    chk("f0_fe", {7'd0, FE}, 8'h00);
    chk("f0_rf", {7'd0, RF}, 8'h01);
    pulse_read();

    // start glitch shorter than half a bit
    while (cyc[1:0] != 2'b00) @(negedge clk);
    RxD = 1'b0;
    repeat (16) @(negedge clk);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    chk("glitch_busy_seen", {7'd0, busy}, 8'h01);
    repeat (44) @(negedge clk);
    chk("glitch_busy", {7'd0, busy}, 8'h00);
    chk("glitch_rf", {7'd0, RF}, 8'h00);

    // reset in the middle of a frame
    send_byte(8'h3C, 1'b1, 1'b0);
    while (cyc[1:0] != 2'b00) @(negedge clk);
    RxD = 1'b0;
    repeat (64) @(negedge clk);
    RxD = 1'b1;
    repeat (200) @(negedge clk);
    chk("pre_rst_busy", {7'd0, busy}, 8'h01);
    resetn = 1'b0;
    @(negedge clk);
    chk("mrst_dout", dout, 8'h00);
    chk("mrst_rf", {7'd0, RF}, 8'h00);
    chk("mrst_busy", {7'd0, busy}, 8'h00);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (100) @(negedge clk);
    send_byte(8'h81, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("post_rst_dout", dout, 8'h81);
    chk("post_rst_rf", {7'd0, RF}, 8'h01);
    chk("post_rst_oe", {7'd0, OE}, 8'h00);
    chk("post_rst_fe", {7'd0, FE}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
